// File: rtl/axi_wr_tlp_s_if.sv
// AXI4 write-channel slave port plus the outbound PCIe MWr TLP request stream,
// bundled so the bridge and its environment connect through one handle.
interface axi_wr_tlp_s_if #(
    parameter int DOUBLE_WORD    = 32,
    parameter int HEADER_SIZE    = 4 * DOUBLE_WORD,
    parameter int TLP_DATA_WIDTH = 8 * DOUBLE_WORD,
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 8
);
    // AW channel
    logic [AXI_ID_WIDTH-1:0]     axi_awid;
    logic [AXI_ADDR_WIDTH-1:0]   axi_awaddr;
    logic [7:0]                  axi_awlen;
    logic [2:0]                  axi_awsize;
    logic [1:0]                  axi_awburst;
    logic                        axi_awvalid;
    logic                        axi_awready;
    // W channel
    logic [TLP_DATA_WIDTH-1:0]   axi_wdata;
    logic [TLP_DATA_WIDTH/8-1:0] axi_wstrb;
    logic                        axi_wlast;
    logic                        axi_wvalid;
    logic                        axi_wready;
    // B channel
    logic [AXI_ID_WIDTH-1:0]     axi_bid;
    logic [1:0]                  axi_bresp;
    logic                        axi_bvalid;
    logic                        axi_bready;
    // TLP request stream
    logic [HEADER_SIZE-1:0]      req_tlp_hdr;
    logic [TLP_DATA_WIDTH-1:0]   req_tlp_data;
    logic [TLP_DATA_WIDTH/8-1:0] req_tlp_strb;
    logic                        req_tlp_sop;
    logic                        req_tlp_eop;
    logic                        req_tlp_valid;
    logic                        req_tlp_ready;

    modport slave (
        input  axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awvalid,
        output axi_awready,
        input  axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
        output axi_wready,
        output axi_bid, axi_bresp, axi_bvalid,
        input  axi_bready,
        output req_tlp_hdr, req_tlp_data, req_tlp_strb, req_tlp_sop, req_tlp_eop, req_tlp_valid,
        input  req_tlp_ready
    );

    modport master (
        output axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awvalid,
        input  axi_awready,
        output axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
        input  axi_wready,
        input  axi_bid, axi_bresp, axi_bvalid,
        output axi_bready,
        input  req_tlp_hdr, req_tlp_data, req_tlp_strb, req_tlp_sop, req_tlp_eop, req_tlp_valid,
        output req_tlp_ready
    );
endinterface

// File: rtl/axi_wr_tlp_s.sv
// AXI4 write slave that turns each full-width INCR burst into one PCIe MWr TLP,
// passing W beats straight through and draining/flagging malformed bursts.
module axi_wr_tlp_s #(
    parameter int DOUBLE_WORD    = 32,
    parameter int HEADER_SIZE    = 4 * DOUBLE_WORD,
    parameter int TLP_DATA_WIDTH = 8 * DOUBLE_WORD,
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    axi_wr_tlp_s_if.slave       bus,
    input  logic [15:0]         requester_id,
    output logic                tlp_error
);
    localparam int         BEAT_BYTES  = TLP_DATA_WIDTH / 8;
    localparam int         BEAT_DW     = TLP_DATA_WIDTH / DOUBLE_WORD;
    localparam logic [2:0] BEAT_SIZE   = 3'($clog2(BEAT_BYTES));
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        DRAIN,
        RESP
    } state_e;

    state_e                  state_q, state_d;
    logic [AXI_ID_WIDTH-1:0] awid_q, awid_d;
    logic [7:0]              len_q, len_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [HEADER_SIZE-1:0]  hdr_q, hdr_d;
    logic                    slverr_q, slverr_d;
    logic                    wlast_seen_q, wlast_seen_d;
    logic                    tlp_error_q, tlp_error_d;

    logic                    aw_hs;
    logic                    w_hs;
    logic                    final_beat;
    logic                    aw_err;
    logic [63:0]             addr64;
    logic [7:0]              tag;
    logic [13:0]             beats_w;
    logic [13:0]             end_offset;
    logic [9:0]              length_dw;
    logic [HEADER_SIZE-1:0]  hdr_new;

    logic                        awready;
    logic                        wready;
    logic                        tlp_valid;
    logic                        sop;
    logic                        eop;
    logic                        bvalid;
    logic [AXI_ID_WIDTH-1:0]     bid;
    logic [1:0]                  bresp;
    logic [TLP_DATA_WIDTH-1:0]   tlp_data;
    logic [TLP_DATA_WIDTH/8-1:0] tlp_strb;

    // ---------------------------------------------------------------------
    // AW decode: legality check and header build from the raw request.
    // ---------------------------------------------------------------------
    assign addr64     = 64'(bus.axi_awaddr);
    assign tag        = 8'(bus.axi_awid);
    assign beats_w    = 14'(bus.axi_awlen) + 14'd1;
    // 14-bit sum so a burst ending exactly on the 4KB boundary is still legal.
    assign end_offset = {2'b00, addr64[11:0]} + beats_w * 14'(BEAT_BYTES);
    assign length_dw  = 10'(beats_w * 14'(BEAT_DW));

    assign aw_err = (bus.axi_awsize != BEAT_SIZE)
                 || (bus.axi_awburst != BURST_INCR)
                 || ((addr64 & 64'(BEAT_BYTES - 1)) != 64'd0)
                 || (bus.axi_awlen > 8'd31)
                 || (end_offset > 14'd4096);

    assign hdr_new = HEADER_SIZE'({3'b011, 5'b00000, 14'b0, length_dw,
                                   requester_id, tag, 4'hF, 4'hF,
                                   addr64[63:32],
                                   addr64[31:2], 2'b00});

    assign aw_hs      = (state_q == IDLE) && bus.axi_awvalid;
    assign w_hs       = bus.axi_wvalid && wready;
    assign final_beat = (cnt_q == len_q);

    // ---------------------------------------------------------------------
    // FSM: state register, next-state logic, output logic.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: registers update with non-blocking assignments so every flop
        // samples the pre-edge values regardless of process ordering.
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default before the case so
        // no path leaves it unassigned and a latch cannot be inferred.
        state_d = state_q;
        case (state_q)
            IDLE:  if (bus.axi_awvalid) state_d = aw_err ? DRAIN : DATA;
            DATA:  if (w_hs && final_beat)
                       state_d = (bus.axi_wlast || wlast_seen_q) ? RESP : DRAIN;
            DRAIN: if (w_hs && bus.axi_wlast) state_d = RESP;
            RESP:  if (bus.axi_bready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        awready   = 1'b0;
        wready    = 1'b0;
        tlp_valid = 1'b0;
        sop       = 1'b0;
        eop       = 1'b0;
        bvalid    = 1'b0;
        bid       = '0;
        bresp     = RESP_OKAY;
        tlp_data  = '0;
        tlp_strb  = '0;
        case (state_q)
            // Reset is folded in so awready is low while rst_n is held.
            IDLE: awready = rst_n;
            DATA: begin
                tlp_valid = bus.axi_wvalid;
                wready    = bus.req_tlp_ready;
                tlp_data  = bus.axi_wdata;
                tlp_strb  = bus.axi_wstrb;
                sop       = (cnt_q == 8'd0);
                eop       = final_beat;
            end
            DRAIN: wready = 1'b1;
            RESP: begin
                bvalid = 1'b1;
                bid    = awid_q;
                bresp  = slverr_q ? RESP_SLVERR : RESP_OKAY;
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------------
    // Burst context: ID, length, beat counter, header and error status.
    // ---------------------------------------------------------------------
    always_comb begin
        awid_d       = awid_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        hdr_d        = hdr_q;
        slverr_d     = slverr_q;
        wlast_seen_d = wlast_seen_q;
        tlp_error_d  = 1'b0;
        if (aw_hs) begin
            awid_d       = bus.axi_awid;
            len_d        = bus.axi_awlen;
            cnt_d        = 8'd0;
            hdr_d        = hdr_new;
            slverr_d     = aw_err;
            wlast_seen_d = 1'b0;
            tlp_error_d  = aw_err;
        end else if ((state_q == DATA) && w_hs) begin
            cnt_d = cnt_q + 8'd1;
            if (bus.axi_wlast != final_beat) begin
                tlp_error_d = 1'b1;
                slverr_d    = 1'b1;
            end
            if (bus.axi_wlast) wlast_seen_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            awid_q       <= '0;
            len_q        <= 8'd0;
            cnt_q        <= 8'd0;
            hdr_q        <= '0;
            slverr_q     <= 1'b0;
            wlast_seen_q <= 1'b0;
            tlp_error_q  <= 1'b0;
        end else begin
            awid_q       <= awid_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            hdr_q        <= hdr_d;
            slverr_q     <= slverr_d;
            wlast_seen_q <= wlast_seen_d;
            tlp_error_q  <= tlp_error_d;
        end
    end

    assign bus.axi_awready   = awready;
    assign bus.axi_wready    = wready;
    assign bus.axi_bvalid    = bvalid;
    assign bus.axi_bid       = bid;
    assign bus.axi_bresp     = bresp;
    assign bus.req_tlp_hdr   = hdr_q;
    assign bus.req_tlp_data  = tlp_data;
    assign bus.req_tlp_strb  = tlp_strb;
    assign bus.req_tlp_sop   = sop;
    assign bus.req_tlp_eop   = eop;
    assign bus.req_tlp_valid = tlp_valid;
    assign tlp_error         = tlp_error_q;

endmodule

// File: tb/tb_axi_wr_tlp_s.sv
// Randomized bench for axi_wr_tlp_s: bursts are scored against a transaction-level
// model of what TLP beats, error pulses and B response each burst must produce.
module tb_axi_wr_tlp_s;

    typedef struct {
        logic [255:0] data;
        logic [31:0]  strb;
        bit           sop;
        bit           eop;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tlp_error;
    logic [15:0] req_id = 16'hBEEF;

    int          n_checks = 0;
    int          n_bad = 0;
    int          err_pulses = 0;
    int          rdy_mode = 0;
    beat_t       exp_q[$];
    logic [127:0] exp_hdr = '0;

    axi_wr_tlp_s_if bus ();

    axi_wr_tlp_s dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .requester_id (req_id),
        .tlp_error    (tlp_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // Burst legality from the protocol rules, in plain arithmetic.
    function automatic bit model_err(input logic [63:0] a, input int len,
                                     input logic [2:0] sz, input logic [1:0] bt);
        int unsigned page_off;
        page_off = 32'(a % 64'd4096);
        return (sz != 3'd5) || (bt != 2'b01) || ((a % 64'd32) != 64'd0)
            || (len > 31) || (page_off + 32'((len + 1) * 32) > 32'd4096);
    endfunction

    function automatic logic [127:0] model_hdr(input logic [63:0] a, input int len,
                                               input logic [7:0] id);
        logic [31:0] dw0, dw1, dw2, dw3;
        dw0 = 32'h6000_0000 + 32'(((len + 1) * 8) % 1024);
        dw1 = 32'(req_id) * 32'd65536 + 32'(id) * 32'd256 + 32'hFF;
        dw2 = a[63:32];
        dw3 = a[31:0] & 32'hFFFF_FFFC;
        return {dw0, dw1, dw2, dw3};
    endfunction

    function automatic logic [255:0] rand256();
        return {$urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom};
    endfunction

    // TLP sink behaviour: always ready, toggling, or random.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       bus.req_tlp_ready = 1'b1;
            1:       bus.req_tlp_ready = (bus.req_tlp_ready === 1'b1) ? 1'b0 : 1'b1;
            default: bus.req_tlp_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: scores every TLP beat and counts error-pulse cycles.
    always @(negedge clk) begin
        if (rst_n) begin
            if (tlp_error) err_pulses++;
            if (bus.req_tlp_valid) check("wready_mirror", bus.axi_wready, bus.req_tlp_ready);
            if (bus.req_tlp_valid && bus.req_tlp_ready) begin
                if (exp_q.size() == 0) begin
                    check("tlp_extra_beat", bus.req_tlp_valid, 0);
                end else begin
                    beat_t b;
                    b = exp_q.pop_front();
                    check("tlp_data", bus.req_tlp_data, b.data);
                    check("tlp_strb", bus.req_tlp_strb, b.strb);
                    check("tlp_sop", bus.req_tlp_sop, b.sop);
                    check("tlp_eop", bus.req_tlp_eop, b.eop);
                    if (b.sop) check("tlp_hdr", bus.req_tlp_hdr, exp_hdr);
                end
            end
        end
    end

    task automatic send_aw(input logic [7:0] id, input logic [63:0] a, input logic [7:0] len,
                           input logic [2:0] sz, input logic [1:0] bt);
        int waited = 0;
        bus.axi_awvalid = 1'b1;
        bus.axi_awid    = id;
        bus.axi_awaddr  = a;
        bus.axi_awlen   = len;
        bus.axi_awsize  = sz;
        bus.axi_awburst = bt;
        forever begin
            @(negedge clk);
            if (bus.axi_awready) break;
            waited++;
            if (waited > 200) begin
                check("aw_timeout", bus.axi_awready, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.axi_awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [255:0] d, input logic [31:0] s, input bit last);
        int waited = 0;
        while ($urandom_range(0, 3) == 0) begin
            bus.axi_wvalid = 1'b0;
            @(posedge clk);
            #1;
        end
        bus.axi_wvalid = 1'b1;
        bus.axi_wdata  = d;
        bus.axi_wstrb  = s;
        bus.axi_wlast  = last;
        forever begin
            @(negedge clk);
            if (bus.axi_wready) break;
            waited++;
            if (waited > 200) begin
                check("w_timeout", bus.axi_wready, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.axi_wvalid = 1'b0;
        bus.axi_wlast  = 1'b0;
    endtask

    task automatic wait_b(input logic [7:0] id, input logic [1:0] resp);
        int waited = 0;
        forever begin
            @(negedge clk);
            if (bus.axi_bvalid) break;
            waited++;
            if (waited > 300) begin
                check("b_timeout", bus.axi_bvalid, 1);
                return;
            end
        end
        check("b_id", bus.axi_bid, id);
        check("b_resp", bus.axi_bresp, resp);
        check("aw_blocked_in_resp", bus.axi_awready, 0);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        bus.axi_bready = 1'b1;
        @(posedge clk);
        #1;
        bus.axi_bready = 1'b0;
        check("b_released", bus.axi_bvalid, 0);
    endtask

    // wl_mode: 0 = wlast on final beat, 1 = early wlast only, 2 = wlast one beat late.
    task automatic run_burst(input logic [63:0] a, input int len, input logic [2:0] sz,
                             input logic [1:0] bt, input int wl_mode, input logic [7:0] id);
        bit   err;
        int   nbeats;
        int   mism;
        int   pulses0;
        int   early_idx;
        err       = model_err(a, len, sz, bt);
        exp_hdr   = model_hdr(a, len, id);
        pulses0   = err_pulses;
        nbeats    = (wl_mode == 2) ? len + 2 : len + 1;
        early_idx = (len >= 2) ? 1 : 0;
        mism      = 0;
        send_aw(id, a, 8'(len), sz, bt);
        for (int i = 0; i < nbeats; i++) begin
            bit           last;
            logic [255:0] d;
            logic [31:0]  s;
            case (wl_mode)
                1:       last = (i == early_idx);
                2:       last = (i == len + 1);
                default: last = (i == len);
            endcase
            d = rand256();
            s = $urandom;
            if (!err && i <= len) begin
                exp_q.push_back('{d, s, i == 0, i == len});
                if (last != (i == len)) mism++;
            end
            send_w(d, s, last);
        end
        wait_b(id, (err || mism > 0) ? 2'b10 : 2'b00);
        check("err_pulses", 256'(err_pulses - pulses0), 256'(err ? 1 : mism));
        check("tlp_beats_lost", 256'(exp_q.size()), 0);
        exp_q.delete();
    endtask

    task automatic check_reset_outputs();
        check("rst_awready", bus.axi_awready, 0);
        check("rst_wready", bus.axi_wready, 0);
        check("rst_bvalid", bus.axi_bvalid, 0);
        check("rst_bresp", bus.axi_bresp, 0);
        check("rst_bid", bus.axi_bid, 0);
        check("rst_tlp_valid", bus.req_tlp_valid, 0);
        check("rst_sop", bus.req_tlp_sop, 0);
        check("rst_eop", bus.req_tlp_eop, 0);
        check("rst_hdr", bus.req_tlp_hdr, 0);
        check("rst_tlp_error", tlp_error, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.axi_awvalid = 1'b0;
        bus.axi_awid    = '0;
        bus.axi_awaddr  = '0;
        bus.axi_awlen   = '0;
        bus.axi_awsize  = '0;
        bus.axi_awburst = '0;
        bus.axi_wvalid  = 1'b0;
        bus.axi_wdata   = '0;
        bus.axi_wstrb   = '0;
        bus.axi_wlast   = 1'b0;
        bus.axi_bready  = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Aligned 4-beat burst, sink always ready.
        rdy_mode = 0;
        run_burst(64'h1000, 3, 3'd5, 2'b01, 0, 8'h5A);
        check("hdr_length_32dw", 256'(bus.req_tlp_hdr[105:96]), 256'd32);

        // Crosses the 4KB page: drained, SLVERR.
        run_burst(64'h0FE0, 1, 3'd5, 2'b01, 0, 8'h11);
        // Narrow beat size: drained until wlast, SLVERR.
        run_burst(64'h2000, 2, 3'd2, 2'b01, 0, 8'h22);
        // Burst ending exactly on the 4KB boundary is legal.
        run_burst(64'h1_0000_0F80, 3, 3'd5, 2'b01, 0, 8'h23);
        // Early wlast on beat1 of a 4-beat burst.
        run_burst(64'h3000, 3, 3'd5, 2'b01, 1, 8'h33);
        // Late wlast: final counted beat without wlast, one drained beat.
        run_burst(64'h4000, 2, 3'd5, 2'b01, 2, 8'h44);
        // Sink toggles ready every cycle.
        rdy_mode = 1;
        run_burst(64'hABCD_0000_5000, 7, 3'd5, 2'b01, 0, 8'h55);
        // Maximum legal length, 256 DW.
        rdy_mode = 2;
        run_burst(64'h6000, 31, 3'd5, 2'b01, 0, 8'h66);

        // Reset in the middle of beat2: TLP abandoned, no B.
        rdy_mode = 0;
        exp_hdr = model_hdr(64'h7000, 3, 8'h77);
        send_aw(8'h77, 64'h7000, 8'd3, 3'd5, 2'b01);
        for (int i = 0; i < 2; i++) begin
            logic [255:0] d;
            logic [31:0]  s;
            d = rand256();
            s = $urandom;
            exp_q.push_back('{d, s, i == 0, 1'b0});
            send_w(d, s, 1'b0);
        end
        bus.axi_wvalid = 1'b1;
        bus.axi_wdata  = rand256();
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        check("rst_mid_beats_seen", 256'(exp_q.size()), 0);
        bus.axi_wvalid = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_burst(64'h8000, 1, 3'd5, 2'b01, 0, 8'h88);

        // Randomized bursts, mostly legal.
        for (int n = 0; n < 40; n++) begin
            logic [63:0] a;
            logic [2:0]  sz;
            logic [1:0]  bt;
            int          len;
            int          wm;
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(32, 40) : $urandom_range(0, 31);
            a = {$urandom, $urandom} & ~64'hFFF;
            a[11:5] = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 9) == 0) a[4:0] = 5'($urandom_range(1, 31));
            sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 4)) : 3'd5;
            bt = ($urandom_range(0, 9) == 0) ? 2'b10 : 2'b01;
            wm = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            if (len == 0 && wm == 1) wm = 0;
            if (model_err(a, len, sz, bt)) wm = 0;
            rdy_mode = $urandom_range(0, 2);
            run_burst(a, len, sz, bt, wm, 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
